nanorv32_mem_arbiter: RTL and testbench

- Two-master round-robin arbiter for the nanorv32 native memory interface (valid/ready, addr, wdata, wstrb, rdata, instr).
- Shares one memory/peripheral bus (testbench memory model, output port, test-pass marker) between the nanorv32 core (M0) and a second requester such as a DMA or debug loader (M1).
- Drives the slave bus from registered request copies.
- Provides a bus-timeout watchdog that completes a stuck transfer with an error response.

---
 rtl/nanorv32_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_nanorv32_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanorv32_mem_arbiter.sv
// Two-master round-robin arbiter for the nanorv32 native memory interface.
// M0 (core) and M1 (DMA / debug loader) share one slave bus. The slave is
// driven from registered copies of the winning request. A watchdog completes
// a transfer that the slave never acknowledges and returns ERR_RDATA.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no transfer on the slave bus, arbitrating pending requests
// S_BUSY | mem_valid high, waiting for mem_ready or watchdog expiry
module nanorv32_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic        grant,
    output logic        busy,
    output logic        timeout_err
);

    // Counter only has to reach TIMEOUT_CYCLES-1; a disabled watchdog keeps a 1-bit stub.
    localparam int unsigned   CW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam bit            WD_EN    = (TIMEOUT_CYCLES != 0);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] counter;
    logic          last_grant;
    logic          req_any;
    logic          win_m1;
    logic          wd_fire;
    logic          done;

    // Arbitration: a lone requester wins, a tie goes to the master not served last.
    always_comb begin
        req_any = m0_valid | m1_valid;
        win_m1  = m1_valid & (~m0_valid | ~last_grant);
    end

    // Transfer completion: slave acknowledge has priority over the watchdog.
    always_comb begin
        wd_fire = WD_EN && (counter == CNT_LAST) && !mem_ready;
        done    = (state == S_BUSY) && (mem_ready || wd_fire);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_any) state_nxt = S_BUSY;
            S_BUSY:  if (done)    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Master-side responses; ready is suppressed while reset is asserted.
    always_comb begin
        m0_ready = done & ~reset & ~grant;
        m1_ready = done & ~reset & grant;
        m0_rdata = mem_ready ? mem_rdata : ERR_RDATA;
        m1_rdata = mem_ready ? mem_rdata : ERR_RDATA;
    end

    // Registered slave request, grant history, watchdog counter and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid   <= 1'b0;
            mem_instr   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            counter     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    timeout_err <= 1'b0;
                    if (req_any) begin
                        mem_valid  <= 1'b1;
                        busy       <= 1'b1;
                        grant      <= win_m1;
                        last_grant <= win_m1;
                        counter    <= '0;
                        mem_instr  <= win_m1 ? m1_instr : m0_instr;
                        mem_addr   <= win_m1 ? m1_addr  : m0_addr;
                        mem_wdata  <= win_m1 ? m1_wdata : m0_wdata;
                        mem_wstrb  <= win_m1 ? m1_wstrb : m0_wstrb;
                    end
                end
                S_BUSY: begin
                    if (done) begin
                        mem_valid   <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= wd_fire;
                    end else begin
                        timeout_err <= 1'b0;
                        if (counter != '1) counter <= counter + 1'b1;
                    end
                end
                default: begin
                    mem_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nanorv32_mem_arbiter.sv
// Self-checking bench for nanorv32_mem_arbiter (watchdog shortened to 8 cycles).
// A transaction-level model predicts every output each cycle; directed
// scenarios add literal expectations, then a random phase stresses the model.
module tb_nanorv32_mem_arbiter;

    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        grant, busy, timeout_err;

    int n_vec = 0;
    int n_err = 0;

    // Model: one outstanding transfer described by its owner, captured fields and age.
    bit          m_busy, m_grant, m_last, m_instr, m_terr;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    int          m_age;

    always #5 clk = ~clk;

    nanorv32_mem_arbiter #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic check_all();
        bit e_done;
        e_done = m_busy && !reset && (mem_ready || (m_age == T - 1));
        chk("mem_valid",   mem_valid,   m_busy);
        chk("busy",        busy,        m_busy);
        chk("mem_instr",   mem_instr,   m_instr);
        chk("mem_addr",    mem_addr,    m_addr);
        chk("mem_wdata",   mem_wdata,   m_wdata);
        chk("mem_wstrb",   mem_wstrb,   m_wstrb);
        chk("grant",       grant,       m_grant);
        chk("timeout_err", timeout_err, m_terr);
        chk("m0_ready",    m0_ready,    e_done && !m_grant);
        chk("m1_ready",    m1_ready,    e_done && m_grant);
        if (e_done) begin
            if (m_grant) chk("m1_rdata", m1_rdata, mem_ready ? mem_rdata : ERR);
            else         chk("m0_rdata", m0_rdata, mem_ready ? mem_rdata : ERR);
        end
    endtask

    // Advance the model by one clock using the inputs presented during that cycle.
    task automatic model_step();
        bit w;
        if (reset) begin
            m_busy = 0; m_instr = 0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
            m_grant = 0; m_last = 1; m_terr = 0; m_age = 0;
        end else if (!m_busy) begin
            m_terr = 0;
            if (m0_valid || m1_valid) begin
                w       = (m0_valid && m1_valid) ? !m_last : m1_valid;
                m_instr = w ? m1_instr : m0_instr;
                m_addr  = w ? m1_addr  : m0_addr;
                m_wdata = w ? m1_wdata : m0_wdata;
                m_wstrb = w ? m1_wstrb : m0_wstrb;
                m_grant = w;
                m_last  = w;
                m_busy  = 1;
                m_age   = 0;
            end
        end else if (mem_ready) begin
            m_busy = 0; m_terr = 0;
        end else if (m_age == T - 1) begin
            m_busy = 0; m_terr = 1;
        end else begin
            m_age++;
            m_terr = 0;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        check_all();
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic step();
        at_neg();
        adv();
    endtask

    initial begin
        int k;
        reset = 1; m0_valid = 0; m0_instr = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 0; m1_instr = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        mem_ready = 0; mem_rdata = '0;
        adv();
        adv();
        at_neg();
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);

        // Single M0 read, slave answers on the second BUSY cycle.
        reset = 0; m0_valid = 1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
        adv();
        at_neg();
        chk("rd_latency", mem_valid, 1);
        chk("rd_addr", mem_addr, 32'h0000_0100);
        adv();
        mem_ready = 1; mem_rdata = 32'h1234_5678;
        at_neg();
        chk("rd_m0_ready", m0_ready, 1);
        chk("rd_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("rd_m1_ready", m1_ready, 0);
        adv();
        m0_valid = 0; mem_ready = 0;
        at_neg();
        chk("rd_gap", mem_valid, 0);
        adv();

        // Both masters request continuously out of reset: strict alternation from M0.
        reset = 1; m0_valid = 1; m1_valid = 1; m0_addr = 32'h200; m1_addr = 32'h300;
        adv();
        reset = 0;
        k = 0;
        for (int c = 0; c < 60 && k < 8; c++) begin
            mem_ready = mem_valid;
            mem_rdata = $urandom;
            at_neg();
            if (m0_ready || m1_ready) begin
                chk("rr_order", grant, k % 2);
                k++;
            end
            adv();
        end
        chk("rr_count", k, 8);
        m0_valid = 0; m1_valid = 0; mem_ready = 0;
        step();

        // M1 write: fields must match and stay stable until the slave acknowledges.
        m1_valid = 1; m1_instr = 0; m1_addr = 32'h1000_0000; m1_wdata = 32'h41; m1_wstrb = 4'b0001;
        step();
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("wr_addr", mem_addr, 32'h1000_0000);
            chk("wr_wdata", mem_wdata, 32'h41);
            chk("wr_wstrb", mem_wstrb, 4'b0001);
            chk("wr_wait", m1_ready, 0);
            adv();
        end
        mem_ready = 1; mem_rdata = '0;
        at_neg();
        chk("wr_m1_ready", m1_ready, 1);
        chk("wr_m0_ready", m0_ready, 0);
        adv();
        m1_valid = 0; mem_ready = 0;
        step();

        // Watchdog: slave never answers, completion forced on the 8th BUSY cycle.
        m0_valid = 1; m0_instr = 1; m0_addr = 32'h400;
        step();
        for (int b = 1; b <= 8; b++) begin
            at_neg();
            if (b < 8) begin
                chk("to_early", m0_ready, 0);
            end else begin
                chk("to_ready", m0_ready, 1);
                chk("to_rdata", m0_rdata, 32'hDEAD_BEEF);
                chk("to_flag_lag", timeout_err, 0);
            end
            adv();
        end
        m0_valid = 0;
        at_neg();
        chk("to_pulse", timeout_err, 1);
        adv();
        at_neg();
        chk("to_once", timeout_err, 0);
        adv();
        m0_valid = 1; m0_instr = 0; m0_addr = 32'h500;
        step();
        mem_ready = 1; mem_rdata = 32'h5555_AAAA;
        at_neg();
        chk("to_recover", m0_rdata, 32'h5555_AAAA);
        chk("to_recover_rdy", m0_ready, 1);
        adv();
        m0_valid = 0; mem_ready = 0;
        step();

        // mem_ready on exactly the 8th BUSY cycle wins over the watchdog.
        m0_valid = 1;
        step();
        for (int b = 1; b <= 8; b++) begin
            mem_ready = (b == 8); mem_rdata = 32'hCAFE_F00D;
            at_neg();
            if (b == 8) begin
                chk("edge_ready", m0_ready, 1);
                chk("edge_rdata", m0_rdata, 32'hCAFE_F00D);
            end
            adv();
        end
        m0_valid = 0; mem_ready = 0;
        at_neg();
        chk("edge_no_err", timeout_err, 0);
        adv();

        // One-cycle reset in the middle of a transfer.
        m0_valid = 1; m1_valid = 1;
        step();
        step();
        reset = 1; mem_ready = 1;
        at_neg();
        chk("rst_no_m0_ready", m0_ready, 0);
        chk("rst_no_m1_ready", m1_ready, 0);
        adv();
        reset = 0; mem_ready = 0;
        at_neg();
        chk("rst_valid_low", mem_valid, 0);
        chk("rst_busy_low", busy, 0);
        adv();
        at_neg();
        chk("rst_m0_first", grant, 0);
        chk("rst_restart", mem_valid, 1);
        adv();
        mem_ready = 1;
        step();
        m0_valid = 0; m1_valid = 0; mem_ready = 0;
        step();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            m0_valid  = ($urandom_range(0, 3) != 0);
            m1_valid  = ($urandom_range(0, 3) != 0);
            m0_instr  = $urandom_range(0, 1);
            m1_instr  = $urandom_range(0, 1);
            m0_addr   = $urandom;  m1_addr  = $urandom;
            m0_wdata  = $urandom;  m1_wdata = $urandom;
            m0_wstrb  = 4'($urandom_range(0, 15));
            m1_wstrb  = 4'($urandom_range(0, 15));
            mem_ready = ($urandom_range(0, 5) == 0);
            mem_rdata = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
